clk_freq_monitor: RTL and testbench
===================================

// Module: clk_freq_monitor
// PURPOSE
//   Consumer-side check of the clock/reset generator outputs: measures a divided clock (e.g. clk_1d024M,
//   clk_2d048M) by counting its rising edges in a fixed window of clk_32d768M cycles.
//   Flags out-of-tolerance frequency and a stalled clock.
//   Sits in the 32.768 MHz domain; results feed status registers / ILA for bring-up and run-time health.
// PARAMETERS
//   CNT_W        16     width of edge counter and meas_count
//   GATE_CYCLES  32768  measurement window in clk_32d768M cycles (1 ms)
//   EXP_COUNT    1024   expected edge count per window (1.024 MHz input)
//   TOL          2      allowed |meas_count - EXP_COUNT| for freq_ok
//   LOSS_CYCLES  256    consecutive cycles without an input edge that declare loss
//   SYNC_STAGES  2      synchronizer depth on mon_clk_in (>=2)
// PORTS
//   clk_32d768M  in   1      measurement clock
//   rst_32d768M  in   1      synchronous active-high reset
//   mon_clk_in   in   1      clock under test, sampled as data
//   start        in   1      1-cycle request to run one measurement
//   busy         out  1      measurement in progress
//   done         out  1      1-cycle pulse: results valid
//   meas_count   out  CNT_W  rising edges counted in last window (saturating)
//   freq_ok      out  1      last result within EXP_COUNT +/- TOL and no loss
//   clk_lost     out  1      sticky: LOSS_CYCLES without an edge seen during last window
// BEHAVIOUR
//   - Reset: state=IDLE; busy=0, done=0, meas_count=0, freq_ok=0, clk_lost=0; synchronizer and counters cleared.
//   - mon_clk_in passes through a SYNC_STAGES flop chain, then an edge-detect flop.
//     An edge is counted when sync=1 and prev=0.
//   - FSM: IDLE -> ARM -> GATE -> EVAL -> IDLE.
//     IDLE: start=1 -> ARM, busy<=1. start is ignored in every other state.
//     ARM: SYNC_STAGES+1 cycles to flush stale synchronizer data; edge/window/loss counters cleared; no counting.
//     GATE: exactly GATE_CYCLES cycles; edge counter increments on each detected edge, saturating at 2^CNT_W-1.
//       Loss counter resets on an edge and increments otherwise.
//       Reaching LOSS_CYCLES sets an internal loss flag, which holds for the rest of the window.
//     EVAL: one cycle. Registers meas_count, clk_lost=loss flag, and
//       freq_ok = !loss && (cnt >= EXP_COUNT-TOL) && (cnt <= EXP_COUNT+TOL).
//       Compare uses CNT_W+1 bits; the lower bound clamps at 0 when TOL > EXP_COUNT.
//       Sets done<=1, busy<=0, and returns to IDLE.
//   - Latency: with start accepted at edge T, results and done are registered at edge T+SYNC_STAGES+2+GATE_CYCLES
//     (T+GATE_CYCLES+4 at default SYNC_STAGES=2).
//     done is high for exactly one cycle. busy is high from edge T up to, but not including, the done cycle.
//   - Outputs meas_count/freq_ok/clk_lost hold until the next EVAL; they are not cleared at start.
//   - start in the done cycle (state IDLE) is accepted; back-to-back measurements therefore have no dead cycle.
//   - Reset mid-measurement: immediate return to IDLE with all reset values; no done pulse.
//   - Edge landing on the last GATE cycle is counted; edges during ARM/EVAL/IDLE are not.
//   - Window counter width = clog2(GATE_CYCLES); loss counter width = clog2(LOSS_CYCLES+1), saturating.
// STRUCTURE
//   - Shared package: FSM state enum (IDLE/ARM/GATE/EVAL) and the default window/expected-count constants for
//     each generated rate (32.768M/16.384M/2.048M/1.024M at 1 ms gate).
//   - One sub-module: sync_edge_det (SYNC_STAGES flop chain + rising-edge pulse), reusable elsewhere.
//   - FSM, counters and comparator live in this module.
// TESTING
//   - 1.024 MHz input (period 32 cycles), defaults, start -> done after 32772 cycles; meas_count=1024,
//     freq_ok=1, clk_lost=0.
//   - 2.048 MHz input -> meas_count=2048, freq_ok=0; input with period 31 cycles -> meas_count in 1056..1058, freq_ok=0.
//   - Input held 0 for the whole window -> meas_count=0, clk_lost=1, freq_ok=0; next run with a good clock clears
//     clk_lost to 0.
//   - start pulsed again at cycle 100 of GATE -> ignored, single done; start in the done cycle -> second run
//     begins, busy=1 next cycle.
//   - rst_32d768M for one cycle mid-GATE -> busy=0, outputs 0, no done; a fresh start then completes normally.
//   - CNT_W=8, GATE_CYCLES=1024, input toggling every cycle (512 edges) -> meas_count=255 (saturated), freq_ok=0.

Source files
------------

// File: rtl/clk_freq_monitor_pkg.sv
// Shared types and rate constants for the divided-clock frequency monitor.
// Window/expected-count pairs assume a 1 ms gate in the 32.768 MHz domain.
package clk_freq_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        EVAL = 2'd3
    } mon_state_t;

    localparam int GATE_1MS   = 32768;
    localparam int EXP_32M768 = 32768;
    localparam int EXP_16M384 = 16384;
    localparam int EXP_2M048  = 2048;
    localparam int EXP_1M024  = 1024;

    function automatic int lower_bound(input int exp_count, input int tol);
        return (tol > exp_count) ? 0 : exp_count - tol;
    endfunction

endpackage

// File: rtl/clk_freq_monitor_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by a
// registered rising-edge detector (pulse when sync=1 and prev=0).
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/clk_freq_monitor.sv
// Counts rising edges of a divided clock over a fixed window of
// clk_32d768M cycles; reports count, tolerance check and clock loss.
module clk_freq_monitor
    import clk_freq_monitor_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = GATE_1MS,
    parameter int EXP_COUNT   = EXP_1M024,
    parameter int TOL         = 2,
    parameter int LOSS_CYCLES = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_32d768M,
    input  logic             rst_32d768M,
    input  logic             mon_clk_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] meas_count,
    output logic             freq_ok,
    output logic             clk_lost
);

    localparam int WIN_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int LOSS_W = $clog2(LOSS_CYCLES + 1);
    localparam int ARM_W  = $clog2(SYNC_STAGES + 2);
    localparam int LO_I   = lower_bound(EXP_COUNT, TOL);
    localparam int HI_I   = EXP_COUNT + TOL;
    localparam logic [CNT_W:0] LO = LO_I[CNT_W:0];
    localparam logic [CNT_W:0] HI = HI_I[CNT_W:0];

    mon_state_t        state;
    mon_state_t        state_nxt;
    logic              edge_pulse;
    logic [WIN_W-1:0]  win_cnt;
    logic [ARM_W-1:0]  arm_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [LOSS_W-1:0] loss_cnt;
    logic              loss_flag;
    logic              win_last;
    logic              arm_last;
    logic              in_range;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk_32d768M),
        .rst  (rst_32d768M),
        .d    (mon_clk_in),
        .rise (edge_pulse)
    );

    assign win_last = (win_cnt == WIN_W'(GATE_CYCLES - 1));
    assign arm_last = (arm_cnt == ARM_W'(SYNC_STAGES));
    assign in_range = ({1'b0, edge_cnt} >= LO) &&
                      ({1'b0, edge_cnt} <= HI);

    always_ff @(posedge clk_32d768M) begin
        if (rst_32d768M) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start)    state_nxt = ARM;
            ARM:  if (arm_last) state_nxt = GATE;
            GATE: if (win_last) state_nxt = EVAL;
            EVAL:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // ARM lets stale synchronizer contents drain before counting starts
    always_ff @(posedge clk_32d768M) begin
        if (rst_32d768M) begin
            arm_cnt   <= '0;
            win_cnt   <= '0;
            edge_cnt  <= '0;
            loss_cnt  <= '0;
            loss_flag <= 1'b0;
        end else begin
            unique case (state)
                ARM: begin
                    arm_cnt   <= arm_cnt + 1'b1;
                    win_cnt   <= '0;
                    edge_cnt  <= '0;
                    loss_cnt  <= '0;
                    loss_flag <= 1'b0;
                end
                GATE: begin
                    win_cnt <= win_cnt + 1'b1;
                    if (edge_pulse && (edge_cnt != '1)) begin
                        edge_cnt <= edge_cnt + 1'b1;
                    end
                    if (edge_pulse) begin
                        loss_cnt <= '0;
                    end else if (loss_cnt != LOSS_W'(LOSS_CYCLES)) begin
                        loss_cnt <= loss_cnt + 1'b1;
                    end
                    if (!edge_pulse &&
                        (loss_cnt == LOSS_W'(LOSS_CYCLES - 1))) begin
                        loss_flag <= 1'b1;
                    end
                end
                IDLE, EVAL: begin
                    arm_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_32d768M) begin
        if (rst_32d768M) begin
            done       <= 1'b0;
            meas_count <= '0;
            freq_ok    <= 1'b0;
            clk_lost   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == EVAL) begin
                done       <= 1'b1;
                meas_count <= edge_cnt;
                clk_lost   <= loss_flag;
                freq_ok    <= !loss_flag && in_range;
            end
        end
    end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench: default, scaled-window and 8-bit instances of the
// frequency monitor driven by cycle-exact synthetic input clocks.
module tb_clk_freq_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mon_d, mon_s, mon_t;
    logic start_d, start_s, start_t;
    logic busy_d, busy_s, busy_t;
    logic done_d, done_s, done_t;
    logic ok_d, ok_s, ok_t;
    logic lost_d, lost_s, lost_t;
    logic [15:0] meas_d, meas_s;
    logic [7:0]  meas_t;

    int per_d, per_s, per_t;
    int ph_d, ph_s, ph_t;
    int n_vec, n_bad;

    clk_freq_monitor u_d (
        .clk_32d768M (clk),     .rst_32d768M (rst),
        .mon_clk_in  (mon_d),   .start       (start_d),
        .busy        (busy_d),  .done        (done_d),
        .meas_count  (meas_d),  .freq_ok     (ok_d),
        .clk_lost    (lost_d)
    );

    clk_freq_monitor #(
        .CNT_W (16), .GATE_CYCLES (2048), .EXP_COUNT (64),
        .TOL (1), .LOSS_CYCLES (256), .SYNC_STAGES (2)
    ) u_s (
        .clk_32d768M (clk),     .rst_32d768M (rst),
        .mon_clk_in  (mon_s),   .start       (start_s),
        .busy        (busy_s),  .done        (done_s),
        .meas_count  (meas_s),  .freq_ok     (ok_s),
        .clk_lost    (lost_s)
    );

    clk_freq_monitor #(
        .CNT_W (8), .GATE_CYCLES (1024), .EXP_COUNT (200),
        .TOL (2), .LOSS_CYCLES (256), .SYNC_STAGES (2)
    ) u_t (
        .clk_32d768M (clk),     .rst_32d768M (rst),
        .mon_clk_in  (mon_t),   .start       (start_t),
        .busy        (busy_t),  .done        (done_t),
        .meas_count  (meas_t),  .freq_ok     (ok_t),
        .clk_lost    (lost_t)
    );

    // period in clk cycles; 0 holds the input low
    always @(negedge clk) begin
        ph_d = (per_d > 0) ? (ph_d + 1) % per_d : 0;
        ph_s = (per_s > 0) ? (ph_s + 1) % per_s : 0;
        ph_t = (per_t > 0) ? (ph_t + 1) % per_t : 0;
        mon_d = (per_d > 0) && (ph_d < per_d / 2);
        mon_s = (per_s > 0) && (ph_s < per_s / 2);
        mon_t = (per_t > 0) && (ph_t < per_t / 2);
    end

    typedef struct {
        int period;
        int lo;
        int hi;
        bit ok;
        bit lost;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act,
                           input longint lo, input longint hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d",
                     name, act, lo, hi);
        end
    endtask

    task automatic drive_start(input int w, input logic v);
        case (w)
            0:       start_d = v;
            1:       start_s = v;
            default: start_t = v;
        endcase
    endtask

    function automatic logic dn(input int w);
        case (w)
            0:       return done_d;
            1:       return done_s;
            default: return done_t;
        endcase
    endfunction

    function automatic logic bz(input int w);
        case (w)
            0:       return busy_d;
            1:       return busy_s;
            default: return busy_t;
        endcase
    endfunction

    // returns with the current negedge being the one where done is seen
    task automatic run(input int w, input int gate, input int poke,
                       output int lat, output int busy_err,
                       output logic fb);
        lat = 0;
        busy_err = 0;
        fb = 1'b0;
        drive_start(w, 1'b1);
        while (lat < gate + 50) begin
            @(negedge clk);
            lat++;
            drive_start(w, (poke != 0) && (lat == poke));
            if (lat == 1) fb = bz(w);
            if (dn(w)) break;
            if (!bz(w)) busy_err++;
        end
    endtask

    initial begin
        int lat, berr, ndone;
        logic fb;

        n_vec = 0;
        n_bad = 0;
        ph_d = 0; ph_s = 0; ph_t = 0;
        per_d = 32; per_s = 32; per_t = 2;
        start_d = 0; start_s = 0; start_t = 0;
        rst = 1'b1;
        tbl[0] = '{32, 64, 64, 1'b1, 1'b0};
        tbl[1] = '{16, 128, 128, 1'b0, 1'b0};
        tbl[2] = '{31, 66, 67, 1'b0, 1'b0};
        tbl[3] = '{0, 0, 0, 1'b0, 1'b1};
        tbl[4] = '{32, 64, 64, 1'b1, 1'b0};
        tbl[5] = '{2, 1024, 1024, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst busy", busy_d, 0);
        chk("rst done", done_d, 0);
        chk("rst meas", meas_d, 0);
        chk("rst ok", ok_d, 0);
        chk("rst lost", lost_d, 0);
        chk("rst meas_s", meas_s, 0);
        chk("rst meas_t", meas_t, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(0, 32768, 104, lat, berr, fb);
        chk("def latency", lat - 1, 32772);
        chk("def busy gaps", berr, 0);
        chk("def first busy", fb, 1);
        chk("def meas", meas_d, 1024);
        chk("def ok", ok_d, 1);
        chk("def lost", lost_d, 0);
        @(negedge clk);
        chk("def done width", done_d, 0);
        chk("def busy after", busy_d, 0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_d) ndone++;
        end
        chk("def single done", ndone, 0);

        foreach (tbl[i]) begin
            per_s = tbl[i].period;
            repeat (4) @(negedge clk);
            run(1, 2048, 0, lat, berr, fb);
            chk($sformatf("tbl%0d latency", i), lat - 1, 2052);
            chk_rng($sformatf("tbl%0d meas", i), meas_s,
                    tbl[i].lo, tbl[i].hi);
            chk($sformatf("tbl%0d ok", i), ok_s, tbl[i].ok);
            chk($sformatf("tbl%0d lost", i), lost_s, tbl[i].lost);
        end

        per_s = 32;
        repeat (4) @(negedge clk);
        run(1, 2048, 0, lat, berr, fb);
        chk("b2b lat1", lat - 1, 2052);
        run(1, 2048, 0, lat, berr, fb);
        chk("b2b first busy", fb, 1);
        chk("b2b lat2", lat - 1, 2052);
        chk("b2b busy gaps", berr, 0);
        chk("b2b meas", meas_s, 64);
        chk("b2b ok", ok_s, 1);
        @(negedge clk);

        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (500) @(negedge clk);
        chk("pre-rst busy", busy_s, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst busy", busy_s, 0);
        chk("mid rst done", done_s, 0);
        chk("mid rst meas", meas_s, 0);
        chk("mid rst ok", ok_s, 0);
        chk("mid rst lost", lost_s, 0);
        ndone = 0;
        repeat (2100) begin
            @(negedge clk);
            if (done_s) ndone++;
        end
        chk("mid rst no done", ndone, 0);
        run(1, 2048, 0, lat, berr, fb);
        chk("post rst latency", lat - 1, 2052);
        chk("post rst meas", meas_s, 64);
        chk("post rst ok", ok_s, 1);

        run(2, 1024, 0, lat, berr, fb);
        chk("sat latency", lat - 1, 1028);
        chk("sat meas", meas_t, 255);
        chk("sat ok", ok_t, 0);
        chk("sat lost", lost_t, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
